// File: rtl/e1_crc_engine.sv
// Parametrised block CRC engine: accumulates NB bits per beat over framed blocks,
// latches the result at block end and compares it with a reference. Optional error counter: E1_CRC_ERRCNT_EN.
module e1_crc_engine #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'h3,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               NB    = 1,
  parameter int               ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NB-1:0]    in_data,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ref_crc,
  output logic [WIDTH-1:0] out_crc,
  output logic             out_valid,
  output logic             out_match,
  output logic             out_abort,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             dbg_state
);

  // Input beats are qualified by in_valid alone; there is no backpressure.
  // out_valid and out_abort are single-cycle pulses with no ready.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] out_crc_q, out_crc_d;
  logic             out_valid_q, out_valid_d;
  logic             out_match_q, out_match_d;
  logic             out_abort_q, out_abort_d;
  logic [WIDTH-1:0] crc_next;
  logic             fb;

  // Bit-serial update unrolled NB times; in_data[NB-1] is shifted in first.
  always_comb begin
    crc_next = in_first ? INIT : state_q;
    fb       = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      fb       = crc_next[WIDTH-1] ^ in_data[i];
      crc_next = {crc_next[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    out_crc_d   = out_crc_q;
    out_match_d = out_match_q;
    out_valid_d = 1'b0;
    out_abort_d = 1'b0;
    if (in_valid) begin
      if (in_first || fsm_q == RUN) begin
        state_d = crc_next;
        // A new first beat while a block is open throws the old block away.
        if (in_first && fsm_q == RUN) out_abort_d = 1'b1;
        if (in_last) begin
          fsm_d       = IDLE;
          out_crc_d   = crc_next;
          out_match_d = (crc_next == ref_crc);
          out_valid_d = 1'b1;
        end else begin
          fsm_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= INIT;
      out_crc_q   <= '0;
      out_valid_q <= 1'b0;
      out_match_q <= 1'b0;
      out_abort_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      out_crc_q   <= out_crc_d;
      out_valid_q <= out_valid_d;
      out_match_q <= out_match_d;
      out_abort_q <= out_abort_d;
    end
  end

  assign out_crc   = out_crc_q;
  assign out_valid = out_valid_q;
  assign out_match = out_match_q;
  assign out_abort = out_abort_q;
  assign dbg_state = fsm_q;

`ifdef E1_CRC_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_d && !out_match_d && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: doc/e1_crc_engine.md
Name: e1_crc_engine

Overview:
- Parametrised block-CRC engine; successor to the single-bit CRC4 accumulator.
- Accumulates a CRC of configurable width and polynomial over framed blocks, NB bits per beat.
- At block end, latches the result and compares it against a reference CRC.
- Used on E1 TX (CRC-4 insertion, sub-multiframe checks) and RX (CRC-4 verification); reusable for other CRC widths in the framer.

Parameters:
- WIDTH, 4, CRC width in bits (2..16).
- POLY, 4'h3, polynomial without the implicit x^WIDTH term, WIDTH bits.
- INIT, 0, state loaded on the first beat of a block.
- NB, 1, data bits per beat (1..8); in_data[NB-1] is the earliest bit.
- ERR_W, 8, error counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  NB  data bits, MSB first in time
- in_first  in  1  beat is the first of a block
- in_last  in  1  beat is the last of a block
- in_valid  in  1  beat qualifier
- ref_crc  in  WIDTH  expected CRC; sampled on the in_last beat
- out_crc  out  WIDTH  CRC of the last completed block
- out_valid  out  1  one-cycle pulse: out_crc/out_match updated
- out_match  out  1  out_crc == sampled ref_crc
- out_abort  out  1  one-cycle pulse: block restarted before in_last
- err_cnt  out  ERR_W  saturating mismatch count (feature only)
- err_clr  in  1  clear err_cnt (feature only)

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Reset values: state=INIT, fsm=IDLE, out_crc=0, out_valid=0, out_match=0, out_abort=0, err_cnt=0.
- Per-bit update, applied NB times combinationally per beat in order in_data[NB-1] down to in_data[0]:
  - fb = s[WIDTH-1] ^ bit
  - s = {s[WIDTH-2:0],0} ^ (fb ? POLY : 0)
- For the first bit of a beat, s is INIT when in_first=1, otherwise the state register. No reflection, no final XOR.
- FSM IDLE / RUN; all transitions require in_valid=1:
  - IDLE, in_first=0: beat ignored; state unchanged.
  - IDLE, in_first=1, in_last=0: accumulate from INIT; go to RUN.
  - IDLE, in_first=1, in_last=1: single-beat block; compute from INIT, complete, stay IDLE.
  - RUN, in_first=0, in_last=0: accumulate.
  - RUN, in_first=0, in_last=1: accumulate, complete, go to IDLE.
  - RUN, in_first=1: out_abort pulses next cycle. The old block is discarded without a result; the new block starts from INIT. If in_last=1 on the same beat, the single-beat block also completes and the FSM goes to IDLE.
- in_valid=0: no state change; in_first and in_last are ignored.
- Completion, registered with 1-cycle latency after the in_last beat:
  - out_crc <= the new state.
  - out_match <= (new state == ref_crc).
  - out_valid=1 for exactly one cycle.
  - out_crc and out_match hold until the next completion.
- Back-to-back blocks (in_last followed by in_first on the next beat): zero bubble; out_valid pulses on consecutive completions.
- rst mid-block: block discarded, no out_valid or out_abort, FSM returns to IDLE.

Optional Feature:
- Macro: E1_CRC_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each completion with a mismatch and saturates at 2^ERR_W-1.
  - err_clr=1 sets err_cnt to 0. A clear takes priority over a same-cycle increment.
- Undefined: err_cnt is tied to 0, err_clr is unused, and no counter logic is built.

Test Plan:
- Defaults (WIDTH=4, POLY=3, NB=1): bits 1,0,0,0, first on bit 1, last on bit 4, ref_crc=4'hB -> out_crc=4'hB, out_match=1, out_valid pulse 1 cycle after the last beat.
- Same stream with ref_crc=4'h3 -> out_crc=4'hB, out_match=0; with the feature enabled, err_cnt goes 0 -> 1; err_clr -> 0.
- Single beat: data 1 with first=last=1 -> out_crc=4'h3. Then an immediate next block 1,0,0,0 -> second out_valid pulse with 4'hB, no bubble.
- NB=4: one beat 4'b1000 with first=last=1 -> out_crc=4'hB one cycle later. Beats with in_valid=0 interleaved in a multi-beat block do not alter the result.
- Abort: 2 bits of a block, then a new in_first -> out_abort pulse. The new block's bits 1,0,0,0 give 4'hB. Beats in IDLE with in_first=0 produce no output.
- Saturation (ERR_W=2, feature on): 5 mismatching blocks -> err_cnt=3. rst mid-block -> all outputs 0 and no out_valid.
